// File: rtl/ysyx_201979054_decode_pkg.sv
// Shared types and constants for the RV64I decode stage: immediate-type encoding,
// opcode values, buffer states and the NOP word used as the reset payload.
package ysyx_201979054_decode_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_CSR = 3'b101
  } imm_src_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  // One buffered instruction with its decode result captured alongside.
  typedef struct packed {
    logic [31:0] instr;
    imm_src_e    imm_src;
    logic        illegal;
  } entry_t;

  localparam entry_t NOP_ENTRY = '{instr: NOP_INSTR, imm_src: IMM_I, illegal: 1'b0};

endpackage

// File: rtl/ysyx_201979054_decode_stage_imm_src_decode.sv
// Combinational opcode classifier: immediate type and illegal flag.
// SYSTEM opcode handling depends on macro YSYX_201979054_CSR_EN.
module ysyx_201979054_imm_src_decode
  import ysyx_201979054_decode_pkg::*;
(
  input  logic [31:0] instr,
  output imm_src_e    imm_src,
  output logic        illegal
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];

  // Map opcode to immediate format; unknown opcodes fall back to I with illegal set.
  always_comb begin
    imm_src = IMM_I;
    illegal = 1'b0;
    case (opcode_s)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: imm_src = IMM_I;
      OP_STORE:                            imm_src = IMM_S;
      OP_BRANCH:                           imm_src = IMM_B;
      OP_JAL:                              imm_src = IMM_J;
      OP_LUI, OP_AUIPC:                    imm_src = IMM_U;
      OP_OP32, OP_OP, OP_FENCE:            imm_src = IMM_I;
      OP_SYSTEM: begin
`ifdef YSYX_201979054_CSR_EN
        // funct3[2] selects the zimm (uimm) CSR forms; ECALL/EBREAK/MRET and register CSR ops use I
        if (funct3_s[2]) begin
          imm_src = IMM_CSR;
        end else begin
          imm_src = IMM_I;
        end
        illegal = 1'b0;
`else
        imm_src = IMM_I;
        illegal = (funct3_s == funct3_s);
`endif
      end
      default: begin
        imm_src = IMM_I;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_201979054_decode_stage.sv
// Decode stage: 2-entry skid buffer (main + skid) carrying the instruction word and
// its pre-decoded immediate type. Macro YSYX_201979054_CSR_EN enables CSR uimm decode.
module ysyx_201979054_decode_stage
  import ysyx_201979054_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instr,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [24:0] o_imm,
  output logic [2:0]  o_imm_src,
  output logic        o_illegal
);

  state_e   state_r, state_s;
  entry_t   main_r, main_s;
  entry_t   skid_r, skid_s;
  entry_t   in_entry_s;
  imm_src_e dec_imm_src_s;
  logic     dec_illegal_s;
  logic     valid_r, valid_s;
  logic     ready_r, ready_s;
  logic     in_xfer_s;
  logic     out_xfer_s;

  ysyx_201979054_imm_src_decode u_imm_src_decode (
    .instr   (i_instr),
    .imm_src (dec_imm_src_s),
    .illegal (dec_illegal_s)
  );

  assign in_entry_s = '{instr: i_instr, imm_src: dec_imm_src_s, illegal: dec_illegal_s};

  // ready_r only reflects the skid slot; rst masks it so nothing is accepted in the reset cycle
  assign o_ready    = ready_r & ~rst;
  assign o_valid    = valid_r;
  assign in_xfer_s  = i_valid & o_ready;
  assign out_xfer_s = valid_r & i_ready;

  // Next-state, entry movement and registered handshake flags.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (i_flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_s = ST_ONE;
            main_s  = in_entry_s;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            state_s = ST_ONE;
            main_s  = in_entry_s;
          end else if (in_xfer_s) begin
            state_s = ST_FULL;
            skid_s  = in_entry_s;
          end else if (out_xfer_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            state_s = ST_ONE;
            main_s  = skid_r;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: state_s = ST_EMPTY;
      endcase
    end
    valid_s = (state_s != ST_EMPTY);
    ready_s = (state_s != ST_FULL);
  end

  // Buffer and handshake registers; reset loads a NOP so payload is never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      main_r  <= NOP_ENTRY;
      skid_r  <= NOP_ENTRY;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
      valid_r <= valid_s;
      ready_r <= ready_s;
    end
  end

  assign o_instr   = main_r.instr;
  assign o_imm     = main_r.instr[31:7];
  assign o_imm_src = main_r.imm_src;
  assign o_illegal = main_r.illegal;

endmodule

// File: tb/tb_ysyx_201979054_decode_stage.sv
// Scoreboard bench for the decode stage: stimulus pushes expected entries on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_ysyx_201979054_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_instr = 32'h0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_instr;
  logic [24:0] o_imm;
  logic [2:0]  o_imm_src;
  logic        o_illegal;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   pop_cyc_q[$];

`ifdef YSYX_201979054_CSR_EN
  localparam logic [2:0] CSR_SRC = 3'b101;
  localparam logic       CSR_ILL = 1'b0;
`else
  localparam logic [2:0] CSR_SRC = 3'b000;
  localparam logic       CSR_ILL = 1'b1;
`endif

  ysyx_201979054_decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .i_instr   (i_instr),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_instr   (o_instr),
    .o_imm     (o_imm),
    .o_imm_src (o_imm_src),
    .o_illegal (o_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one word; push the expected entry at the edge where it is accepted.
  task automatic send(input logic [31:0] w, input logic [2:0] src, input logic ill);
    exp_t e;
    bit acc = 1'b0;
    i_valid = 1'b1;
    i_instr = w;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_ready) begin
        e.instr = w; e.imm_src = src; e.illegal = ill;
        exp_q.push_back(e);
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output transfer against the scoreboard head.
  initial begin
    exp_t e;
    logic [31:0] ei;
    forever begin
      @(negedge clk);
      if (!rst && !i_flush && o_valid && i_ready) begin
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_out", o_instr, 32'hxxxxxxxx);
        end else begin
          e  = exp_q.pop_front();
          ei = e.instr;
          chk("out_instr", o_instr, ei);
          chk("out_imm", {7'd0, o_imm}, {7'd0, ei[31:7]});
          chk("out_imm_src", {29'd0, o_imm_src}, {29'd0, e.imm_src});
          chk("out_illegal", {31'd0, o_illegal}, {31'd0, e.illegal});
        end
      end
    end
  end

  initial begin
    // reset values while rst is held
    idle(2);
    @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_instr", o_instr, 32'h00000013);
    chk("rst_imm", {7'd0, o_imm}, 32'd0);
    chk("rst_imm_src", {29'd0, o_imm_src}, 32'd0);
    chk("rst_illegal", {31'd0, o_illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;

    // single addi, one-cycle latency and known immediate
    i_ready = 1'b1;
    send(32'h00500093, 3'b000, 1'b0);
    @(negedge clk);
    chk("lat1_valid", {31'd0, o_valid}, 32'd1);
    chk("lat1_imm", {7'd0, o_imm}, 32'h0000A001);
    idle(2);

    // back-to-back S/B/J/U with no bubbles
    pop_cyc_q.delete();
    send(32'h00112623, 3'b001, 1'b0);
    send(32'h00208463, 3'b010, 1'b0);
    send(32'h0080006F, 3'b011, 1'b0);
    send(32'h000012B7, 3'b100, 1'b0);
    idle(3);
    chk("b2b_count", pop_cyc_q.size(), 32'd4);
    if (pop_cyc_q.size() == 4) begin
      for (int k = 1; k < 4; k++) chk("b2b_no_bubble", pop_cyc_q[k] - pop_cyc_q[k-1], 32'd1);
    end

    // other legal opcodes, CSR, all-ones illegal
    send(32'h00000033, 3'b000, 1'b0);
    send(32'h0000000F, 3'b000, 1'b0);
    send(32'h34015073, CSR_SRC, CSR_ILL);
    send(32'hFFFFFFFF, 3'b000, 1'b1);
    idle(3);

    // backpressure: fill, hold third word upstream, then release
    i_ready = 1'b0;
    send(32'h00A00113, 3'b000, 1'b0);
    send(32'h00B00193, 3'b000, 1'b0);
    i_valid = 1'b1;
    i_instr = 32'h00C00213;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("full_ready", {31'd0, o_ready}, 32'd0);
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_instr", o_instr, 32'h00A00113);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    send(32'h00C00213, 3'b000, 1'b0);
    idle(4);

    // flush in FULL drops buffered words and the offered one
    i_ready = 1'b0;
    send(32'h00D00293, 3'b000, 1'b0);
    send(32'h00E00313, 3'b000, 1'b0);
    i_valid = 1'b1;
    i_instr = 32'h00F00393;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    i_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("flush_lost", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;

    // reset in FULL (with flush also high) restores reset values
    i_ready = 1'b0;
    send(32'h01000413, 3'b000, 1'b0);
    send(32'h00112623, 3'b001, 1'b0);
    rst = 1'b1;
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_instr = 32'h0080006F;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("rst2_valid", {31'd0, o_valid}, 32'd0);
    chk("rst2_ready", {31'd0, o_ready}, 32'd0);
    chk("rst2_instr", o_instr, 32'h00000013);
    chk("rst2_imm", {7'd0, o_imm}, 32'd0);
    chk("rst2_imm_src", {29'd0, o_imm_src}, 32'd0);
    chk("rst2_illegal", {31'd0, o_illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("rst2_ready_after", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;

    // a word after reset still flows
    i_ready = 1'b1;
    send(32'h000012B7, 3'b100, 1'b0);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
